// File: rtl/strobe_decoder_2x4_pkg.sv
// Shared types and helpers for the 2x4 strobe decoder.
// Holds the FSM state encoding and the one-hot code decode.
package strobe_dec_pkg;

    localparam int CODE_W = 2;
    localparam int OUT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

    function automatic logic [OUT_W-1:0] onehot(
        input logic [CODE_W-1:0] code
    );
        return OUT_W'(1) << code;
    endfunction

endpackage

// File: rtl/strobe_decoder_2x4_if.sv
// Code-input handshake bundle for the strobe decoder.
// The producer drives valid/code; the decoder drives ready.
interface strobe_decoder_2x4_if;
    import strobe_dec_pkg::*;

    logic              in_valid;
    logic [CODE_W-1:0] in_code;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_code,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_code,
        output in_ready
    );

endinterface

// File: rtl/strobe_decoder_2x4_fifo.sv
// Small code FIFO: power-of-two depth, wrapping pointers.
// Callers guarantee push only when !full and pop only when !empty.
module code_fifo
    import strobe_dec_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [CODE_W-1:0]      din,
    output logic [CODE_W-1:0]      head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [CODE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign head  = mem[rptr];
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/strobe_decoder_2x4.sv
// Buffers 2-bit channel codes and replays each as a one-hot
// strobe of PULSE_LEN cycles followed by GAP_LEN idle cycles.
module strobe_decoder_2x4
    import strobe_dec_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PULSE_LEN = 3,
    parameter int GAP_LEN   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    strobe_decoder_2x4_if.slave    bus,
    output logic [OUT_W-1:0]       dout,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int CMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] PULSE_RLD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] GAP_RLD   = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [OUT_W-1:0]  dout_n;
    logic [CODE_W-1:0] head;
    logic              full, empty;
    logic              push, pop, launch;

    // ready is forced low while reset is held, not just after the edge
    assign bus.in_ready = !full && !rst;
    assign push         = bus.in_valid && bus.in_ready;
    assign launch       = enable && !empty;
    assign busy         = (state != IDLE);

    code_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.in_code),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dout     <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dout  <= dout_n;
            if (bus.in_valid && !bus.in_ready) overflow <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dout_n  = dout;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                dout_n = '0;
                if (launch) begin
                    pop     = 1'b1;
                    dout_n  = onehot(head);
                    cnt_n   = PULSE_RLD;
                    state_n = PULSE;
                end
            end
            PULSE: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (GAP_LEN > 0) begin
                    dout_n  = '0;
                    cnt_n   = GAP_RLD;
                    state_n = GAP;
                end else if (launch) begin
                    pop     = 1'b1;
                    dout_n  = onehot(head);
                    cnt_n   = PULSE_RLD;
                end else begin
                    dout_n  = '0;
                    state_n = IDLE;
                end
            end
            GAP: begin
                dout_n = '0;
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (launch) begin
                    pop     = 1'b1;
                    dout_n  = onehot(head);
                    cnt_n   = PULSE_RLD;
                    state_n = PULSE;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                dout_n  = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule
